// File: rtl/display_pkg.sv
// Shared constants, phase encoding and hex-to-segment table for the display scanner.
// Pure definitions: no latency and no backpressure.
package display_pkg;

  localparam int DEF_NUM_DIGITS = 8;
  localparam int DEF_TICK_DIV   = 50000;
  localparam int DEF_BLANK_CYC  = 16;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef enum logic {
    PH_BLANK = 1'b0,
    PH_DRIVE = 1'b1
  } phase_t;

  // Active-low {g,f,e,d,c,b,a}; lowercase glyphs for b and d keep them distinct from 8 and 0.
  function automatic logic [6:0] hex_to_seg7_n(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/scan_display_ctrl_if.sv
// Host frame-write port: one frame of nibbles plus dp/blank masks per transfer.
// A transfer completes when wr_valid && wr_ready; the host holds its request while wr_ready is low.
interface scan_display_ctrl_if
  import display_pkg::*;
#(
  parameter int NUM_DIGITS = DEF_NUM_DIGITS
);

  logic                      wr_valid;
  logic                      wr_ready;
  logic [4*NUM_DIGITS-1:0]   wr_data;
  logic [NUM_DIGITS-1:0]     dp_mask;
  logic [NUM_DIGITS-1:0]     blank_mask;

  modport master (
    output wr_valid, wr_data, dp_mask, blank_mask,
    input  wr_ready
  );

  modport slave (
    input  wr_valid, wr_data, dp_mask, blank_mask,
    output wr_ready
  );

endinterface

// File: rtl/scan_display_ctrl_seg7_decode.sv
// Combinational nibble + decimal point to active-low {dp,g..a} segment pattern.
// Zero latency, no handshake.
module seg7_decode
  import display_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  output logic [7:0] seg_n
);

  assign seg_n = {~dp, hex_to_seg7_n(nibble)};

endmodule

// File: rtl/scan_display_ctrl.sv
// Double-buffered seven-segment scanner: one digit per TICK_DIV-cycle slot, blanked for BLANK_CYC at slot start.
// Outputs registered (1 cycle behind cnt/idx); wr_ready drops while a frame waits for the next frame boundary.
module scan_display_ctrl
  import display_pkg::*;
#(
  parameter int NUM_DIGITS = DEF_NUM_DIGITS,
  parameter int TICK_DIV   = DEF_TICK_DIV,
  parameter int BLANK_CYC  = DEF_BLANK_CYC
) (
  input  logic                  pixel_clk,
  input  logic                  reset,
  scan_display_ctrl_if.slave    wr,
  output logic [7:0]            seg_n,
  output logic [NUM_DIGITS-1:0] an_n,
  output logic                  frame_start
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam phase_t           PH_RESET = (BLANK_CYC > 0) ? PH_BLANK : PH_DRIVE;

  logic [CNT_W-1:0]             cnt;
  logic [IDX_W-1:0]             idx;
  phase_t                       phase;
  logic                         slot_end;
  logic                         frame_end;
  logic                         accept;
  logic                         pending;
  logic [NUM_DIGITS-1:0][3:0]   pend_data;
  logic [NUM_DIGITS-1:0][3:0]   shadow_data;
  logic [NUM_DIGITS-1:0]        pend_dp;
  logic [NUM_DIGITS-1:0]        pend_blank;
  logic [NUM_DIGITS-1:0]        shadow_dp;
  logic [NUM_DIGITS-1:0]        shadow_blank;
  logic [7:0]                   dig_seg_n;

  assign slot_end    = (cnt == CNT_LAST);
  assign frame_end   = slot_end && (idx == IDX_LAST);
  assign accept      = wr.wr_valid && !pending;
  assign wr.wr_ready = ~pending;

  seg7_decode u_seg7_decode (
    .nibble (shadow_data[idx]),
    .dp     (shadow_dp[idx]),
    .seg_n  (dig_seg_n)
  );

  // phase always mirrors (cnt < BLANK_CYC); tracking it as state keeps the
  // wide magnitude compare off the output path.
  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      cnt         <= '0;
      idx         <= '0;
      phase       <= PH_RESET;
      seg_n       <= SEG_BLANK;
      an_n        <= '1;
      frame_start <= 1'b0;
    end else begin
      if (slot_end) begin
        cnt <= '0;
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end

      case (phase)
        PH_BLANK: if (int'(cnt) == BLANK_CYC - 1) phase <= PH_DRIVE;
        PH_DRIVE: if (slot_end && BLANK_CYC > 0)  phase <= PH_BLANK;
        default:  phase <= PH_RESET;
      endcase

      frame_start <= (cnt == '0) && (idx == '0);

      if (phase == PH_BLANK || shadow_blank[idx]) begin
        seg_n <= SEG_BLANK;
        an_n  <= '1;
      end else begin
        seg_n <= dig_seg_n;
        an_n  <= ~(NUM_DIGITS'(1) << idx);
      end
    end
  end

  // Shadow only changes on a frame boundary, so a scan never mixes two frames.
  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      pending      <= 1'b0;
      pend_data    <= '0;
      pend_dp      <= '0;
      pend_blank   <= '0;
      shadow_data  <= '0;
      shadow_dp    <= '0;
      shadow_blank <= '0;
    end else if (accept) begin
      pending    <= 1'b1;
      pend_data  <= wr.wr_data;
      pend_dp    <= wr.dp_mask;
      pend_blank <= wr.blank_mask;
    end else if (frame_end && pending) begin
      pending      <= 1'b0;
      shadow_data  <= pend_data;
      shadow_dp    <= pend_dp;
      shadow_blank <= pend_blank;
    end
  end

endmodule

// File: tb/tb_scan_display_ctrl.sv
// Directed bench for scan_display_ctrl with a cycle-position reference model and literal spot checks.
module tb_scan_display_ctrl;

  localparam int ND    = 4;
  localparam int TD    = 10;
  localparam int BC    = 2;
  localparam int FRAME = ND * TD;

  logic          pixel_clk = 1'b0;
  logic          reset     = 1'b1;
  logic [7:0]    seg_n;
  logic [ND-1:0] an_n;
  logic          frame_start;

  scan_display_ctrl_if #(.NUM_DIGITS(ND)) wr_if ();

  scan_display_ctrl #(
    .NUM_DIGITS (ND),
    .TICK_DIV   (TD),
    .BLANK_CYC  (BC)
  ) dut (
    .pixel_clk   (pixel_clk),
    .reset       (reset),
    .wr          (wr_if),
    .seg_n       (seg_n),
    .an_n        (an_n),
    .frame_start (frame_start)
  );

  always #5 pixel_clk = ~pixel_clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %0h, required %0h", nm, $time, act, req);
    end
  endtask

  // Reference: position within the frame since reset release, plus frame-level buffers.
  logic [6:0] seg_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  int          m_pos;
  bit          m_pending;
  logic [15:0] m_pd, m_sd;
  logic [3:0]  m_pdp, m_pbl, m_sdp, m_sbl;
  logic [7:0]  exp_seg;
  logic [3:0]  exp_an;
  logic        exp_fs, exp_rdy;
  bit          model_valid = 0;
  int          mc, md;

  always @(posedge pixel_clk) begin
    if (reset) begin
      m_pos = 0; m_pending = 0;
      m_pd = '0; m_sd = '0; m_pdp = '0; m_pbl = '0; m_sdp = '0; m_sbl = '0;
      exp_seg = 8'hFF; exp_an = 4'hF; exp_fs = 1'b0;
    end else begin
      mc     = m_pos % TD;
      md     = (m_pos / TD) % ND;
      exp_fs = (m_pos % FRAME == 0);
      if (mc < BC || m_sbl[md]) begin
        exp_seg = 8'hFF;
        exp_an  = 4'hF;
      end else begin
        exp_seg = {~m_sdp[md], seg_tbl[m_sd[4*md +: 4]]};
        exp_an  = ~(4'b0001 << md);
      end
      if (wr_if.wr_valid && !m_pending) begin
        m_pending = 1; m_pd = wr_if.wr_data; m_pdp = wr_if.dp_mask; m_pbl = wr_if.blank_mask;
      end else if (m_pos % FRAME == FRAME - 1 && m_pending) begin
        m_pending = 0; m_sd = m_pd; m_sdp = m_pdp; m_sbl = m_pbl;
      end
      m_pos++;
    end
    exp_rdy     = !m_pending;
    model_valid = 1;
  end

  always @(negedge pixel_clk) begin
    if (model_valid) begin
      check("seg_n", seg_n, exp_seg);
      check("an_n", an_n, exp_an);
      check("frame_start", frame_start, exp_fs);
      check("wr_ready", wr_if.wr_ready, exp_rdy);
      check("an_onehot", ($countones(~an_n) <= 1), 1);
    end
  end

  task automatic wait_to(input int k);
    int guard = 0;
    while (m_pos != k && guard < 500) begin
      @(negedge pixel_clk);
      guard++;
    end
    if (m_pos != k) begin
      n_chk++; n_fail++;
      $display("FAIL wait_to: position %0d, required %0d", m_pos, k);
    end
  endtask

  // Literal pins both the DUT and the reference model.
  task automatic lit(input string nm, input logic [7:0] dut_v, input logic [7:0] mdl_v,
                     input logic [7:0] want);
    check({nm, "_dut"}, dut_v, want);
    check({nm, "_model"}, mdl_v, want);
  endtask

  task automatic drive(input logic v, input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl);
    wr_if.wr_valid   = v;
    wr_if.wr_data    = d;
    wr_if.dp_mask    = dp;
    wr_if.blank_mask = bl;
  endtask

  initial begin
    drive(1'b0, 16'h0, 4'h0, 4'h0);
    reset = 1'b1;
    repeat (3) @(negedge pixel_clk);
    lit("rst_seg", seg_n, exp_seg, 8'hFF);
    lit("rst_an", {4'h0, an_n}, {4'h0, exp_an}, 8'h0F);
    lit("rst_rdy", {7'h0, wr_if.wr_ready}, {7'h0, exp_rdy}, 8'h01);
    reset = 1'b0;

    wait_to(1);  lit("fs_first", {7'h0, frame_start}, {7'h0, exp_fs}, 8'h01);
    wait_to(5);  drive(1'b1, 16'h3210, 4'h0, 4'h0);
    wait_to(6);  drive(1'b0, 16'h0, 4'h0, 4'h0);
    lit("rdy_after_wr", {7'h0, wr_if.wr_ready}, {7'h0, exp_rdy}, 8'h00);
    wait_to(10); drive(1'b1, 16'hFFFF, 4'h0, 4'h0);
    wait_to(39); lit("rdy_held", {7'h0, wr_if.wr_ready}, {7'h0, exp_rdy}, 8'h00);
    wait_to(40); lit("rdy_rise", {7'h0, wr_if.wr_ready}, {7'h0, exp_rdy}, 8'h01);
    wait_to(41); drive(1'b0, 16'h0, 4'h0, 4'h0);
    lit("fs_frame1", {7'h0, frame_start}, {7'h0, exp_fs}, 8'h01);
    lit("blank_seg", seg_n, exp_seg, 8'hFF);
    lit("rdy_reaccept", {7'h0, wr_if.wr_ready}, {7'h0, exp_rdy}, 8'h00);
    wait_to(45); lit("d0_an", {4'h0, an_n}, {4'h0, exp_an}, 8'h0E); lit("d0_seg", seg_n, exp_seg, 8'hC0);
    wait_to(55); lit("d1_an", {4'h0, an_n}, {4'h0, exp_an}, 8'h0D); lit("d1_seg", seg_n, exp_seg, 8'hF9);
    wait_to(65); lit("d2_an", {4'h0, an_n}, {4'h0, exp_an}, 8'h0B); lit("d2_seg", seg_n, exp_seg, 8'hA4);
    wait_to(75); lit("d3_an", {4'h0, an_n}, {4'h0, exp_an}, 8'h07); lit("d3_seg", seg_n, exp_seg, 8'hB0);

    wait_to(80); drive(1'b1, 16'h8888, 4'b0001, 4'b0100);
    wait_to(81); drive(1'b0, 16'h0, 4'h0, 4'h0);
    wait_to(85); lit("ffff_seg", seg_n, exp_seg, 8'h8E);
    wait_to(126); lit("dp_an", {4'h0, an_n}, {4'h0, exp_an}, 8'h0E); lit("dp_seg", seg_n, exp_seg, 8'h00);
    wait_to(136); lit("m1_seg", seg_n, exp_seg, 8'h80);
    wait_to(146); lit("bl_an", {4'h0, an_n}, {4'h0, exp_an}, 8'h0F); lit("bl_seg", seg_n, exp_seg, 8'hFF);
    wait_to(156); lit("m3_an", {4'h0, an_n}, {4'h0, exp_an}, 8'h07); lit("m3_seg", seg_n, exp_seg, 8'h80);

    wait_to(160); drive(1'b1, 16'h1234, 4'hF, 4'h0);
    wait_to(161); drive(1'b0, 16'h0, 4'h0, 4'h0);
    lit("rdy_pend", {7'h0, wr_if.wr_ready}, {7'h0, exp_rdy}, 8'h00);
    wait_to(182); reset = 1'b1;
    repeat (2) @(negedge pixel_clk);
    lit("mid_rst_seg", seg_n, exp_seg, 8'hFF);
    lit("mid_rst_rdy", {7'h0, wr_if.wr_ready}, {7'h0, exp_rdy}, 8'h01);
    reset = 1'b0;
    wait_to(1); lit("fs_after_rst", {7'h0, frame_start}, {7'h0, exp_fs}, 8'h01);
    wait_to(3); lit("zero_an", {4'h0, an_n}, {4'h0, exp_an}, 8'h0E); lit("zero_seg", seg_n, exp_seg, 8'hC0);
    wait_to(45);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time exhausted, required completion before %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/scan_display_ctrl.md
Name: scan_display_ctrl

Overview:
Time-multiplexed scan controller for the multi-digit seven-segment display. It takes a frame of hex digits from the host through a valid/ready write port and double-buffers it. It sequences one digit per slot at a fixed slot rate derived from pixel_clk, inserting a blanking gap at the start of each slot to suppress ghosting. It drives active-low segment and anode lines directly to the pads and is the sole owner of the display timing.

Parameters:
NUM_DIGITS, 8, number of digits scanned; must be >= 2.
TICK_DIV, 50000, pixel_clk cycles per digit slot; must be >= 2.
BLANK_CYC, 16, cycles at the start of each slot with all anodes off; must be < TICK_DIV.

Ports:
pixel_clk  in  1  system clock; all logic is on its rising edge.
reset  in  1  synchronous, active-high reset.
wr_valid  in  1  host offers a new frame.
wr_ready  out  1  controller can accept a frame; the write occurs when wr_valid && wr_ready.
wr_data  in  4*NUM_DIGITS  hex nibbles; digit i = wr_data[4i+3:4i].
dp_mask  in  NUM_DIGITS  decimal-point enable per digit, captured with wr_data.
blank_mask  in  NUM_DIGITS  digit i forced dark when bit set, captured with wr_data.
seg_n  out  8  active-low segments {dp,g,f,e,d,c,b,a}.
an_n  out  NUM_DIGITS  active-low digit enables.
frame_start  out  1  one-cycle pulse at the start of each frame.

Behaviour:
- Reset state (sync, active-high, takes effect at the clock edge):
  - cnt=0, idx=0.
  - shadow data, dp and blank registers = 0.
  - pending=0.
  - seg_n=8'hFF, an_n=all ones, frame_start=0, wr_ready=1.
  - A reset mid-frame drops any pending frame and restarts at digit 0, cnt 0.
- Slot counter:
  - cnt counts 0..TICK_DIV-1, with width $clog2(TICK_DIV).
  - slot_end = (cnt==TICK_DIV-1). On slot_end, cnt goes to 0 and idx advances.
  - idx wraps from NUM_DIGITS-1 to 0. Its width is max(1,$clog2(NUM_DIGITS)).
  - frame_end = slot_end && idx==NUM_DIGITS-1.
  - Frame period = NUM_DIGITS*TICK_DIV cycles.
- Per-slot phases, a two-state FSM decoded from cnt:
  - BLANK (cnt < BLANK_CYC): an_n all ones, seg_n=8'hFF.
  - DRIVE (cnt >= BLANK_CYC):
    - an_n has only bit idx low, unless shadow_blank[idx] is set, in which case an_n is all ones and seg_n=8'hFF.
    - seg_n[6:0] = decode(shadow nibble idx).
    - seg_n[7] = ~shadow_dp[idx].
- Output latency: seg_n, an_n and frame_start are registered. Their value in cycle t+1 reflects cnt/idx/shadow in cycle t.
- frame_start: registered from (cnt==0 && idx==0). It therefore pulses for one cycle, one cycle after the counters enter slot 0.
- Decode table, hex to seg_n[6:0] active-low:
  - 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78
  - 8:00, 9:10, A:08, b:03, C:46, d:21, E:06, F:0E
- Write handshake:
  - wr_ready = ~pending (combinational from a register).
  - On accept, wr_data, dp_mask and blank_mask are latched into pending registers and pending is set.
  - wr_valid while wr_ready=0 is ignored. The host holds the request; data is not queued.
- Shadow update: on frame_end with pending=1, the pending registers copy to shadow and pending clears. wr_ready rises the next cycle.
- Simultaneous accept and frame_end: an accept in the same cycle as frame_end (pending was 0) loads pending only. The shadow updates at the following frame_end. A frame is therefore never torn within a scan.

Decomposition:
- Package display_pkg:
  - SEG_BLANK = 8'hFF.
  - hex_to_seg7_n function, implementing the table above.
  - default parameter constants.
- One combinational sub-module, seg7_decode: input 4-bit nibble and dp, output 8-bit seg_n.
- The counter, FSM, handshake and buffers remain in scan_display_ctrl.

Test Plan:
All tests use NUM_DIGITS=4, TICK_DIV=10, BLANK_CYC=2 (frame = 40 cycles).
1. Reset held 3 cycles, then released -> during and after reset seg_n=FF, an_n=F, wr_ready=1. frame_start pulses at cycle 1 after release, then every 40 cycles.
2. Write wr_data=16'h3210, dp_mask=0, blank_mask=0 at cycle 5 -> wr_ready=0 until the frame_end at cycle 39, then 1. In the next frame: slot 0 drive gives an_n=1110, seg_n=C0; slot 1 gives 1101/F9; slot 2 gives 1011/A4; slot 3 gives 0111/B0.
3. Blanking check -> in every slot, 2 output cycles with an_n=F and seg_n=FF, followed by 8 driven cycles. No slot ever has two an_n bits low.
4. Second write of 16'hFFFF while pending -> not accepted. The display shows 3210 and never FFFF. After wr_ready returns, the held request is accepted and shown from the frame after next.
5. Write 16'h8888 with dp_mask=4'b0001 and blank_mask=4'b0100 -> digit 0 shows seg_n=00 (dp on). Digit 2's slot shows an_n=F for all 10 cycles. Digits 1 and 3 show seg_n=80.
6. Assert reset in slot 2 with a write pending -> after release idx=0, cnt=0 and pending is cleared (wr_ready=1). The shadow is zero, so the next drive cycle shows seg_n=C0 on digit 0.
